// File: rtl/aes_model_pack.sv
// Shared AES model types: block width and the sync-provider state encoding.
package aes_model_pack;

  localparam int DATA_WIDTH_IN_BYTES = 16;

  typedef logic [127:0] aes_block_t;
  typedef logic [1:0]   aes_sync_provider_sm_t;

  localparam aes_sync_provider_sm_t SM_IDLE      = 2'd0;
  localparam aes_sync_provider_sm_t SM_OFFER     = 2'd1;
  localparam aes_sync_provider_sm_t SM_EXHAUSTED = 2'd2;

endpackage

// File: rtl/dvr_key_if.sv
// Key/sync handoff channel: master offers key+sync with valid, slave accepts with rdy.
interface dvr_key_if;
  import aes_model_pack::*;

  aes_block_t key;
  aes_block_t sync;
  logic       valid;
  logic       rdy;

  modport master (output key, output sync, output valid, input rdy);
  modport slave  (input key, input sync, input valid, output rdy);

endinterface

// File: rtl/aes_sync_provider.sv
// Offers {nonce, counter} syncs under a loaded key; one fresh sync per accepted transfer.
// Load/transfer effects visible one cycle later; outputs are pure register decodes, rdy only gates the counter.
module aes_sync_provider
  import aes_model_pack::*;
#(
  parameter int COUNTER_WIDTH = 64,
  parameter int NONCE_WIDTH   = DATA_WIDTH_IN_BYTES*8 - COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  aes_block_t               key_in,
  input  logic [NONCE_WIDTH-1:0]   nonce_in,
  input  logic                     key_load,
  input  logic                     zeroize,
  dvr_key_if.master                key_and_sync,
  output logic [COUNTER_WIDTH-1:0] sync_count,
  output logic                     exhausted
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  aes_sync_provider_sm_t    state_q, state_d;
  aes_block_t               key_q, key_d;
  logic [NONCE_WIDTH-1:0]   nonce_q, nonce_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     xfer;

  assign xfer = (state_q == SM_OFFER) && key_and_sync.rdy;

  always_comb begin
    state_d = state_q;
    if (zeroize) begin
      state_d = SM_IDLE;
    end else if (key_load) begin
      state_d = SM_OFFER;
    end else begin
      case (state_q)
        SM_IDLE:      state_d = SM_IDLE;
        SM_OFFER:     if (xfer && (cnt_q == CNT_MAX)) state_d = SM_EXHAUSTED;
        SM_EXHAUSTED: state_d = SM_EXHAUSTED;
        default:      state_d = SM_IDLE;
      endcase
    end
  end

  // A load on a transfer edge restarts at 0: the completed transfer used the old sync.
  always_comb begin
    key_d   = key_q;
    nonce_d = nonce_q;
    cnt_d   = cnt_q;
    if (zeroize) begin
      key_d   = '0;
      nonce_d = '0;
      cnt_d   = '0;
    end else if (key_load) begin
      key_d   = key_in;
      nonce_d = nonce_in;
      cnt_d   = '0;
    end else if (xfer && (cnt_q != CNT_MAX)) begin
      cnt_d   = cnt_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q   <= '0;
      nonce_q <= '0;
      cnt_q   <= '0;
    end else begin
      key_q   <= key_d;
      nonce_q <= nonce_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_and_sync.key   = key_q;
  assign key_and_sync.sync  = {nonce_q, cnt_q};
  assign key_and_sync.valid = (state_q == SM_OFFER);
  assign sync_count         = cnt_q;
  assign exhausted          = (state_q == SM_EXHAUSTED);

endmodule

// File: tb/tb_aes_sync_provider.sv
// Directed bench: a 64-bit-counter provider for load/transfer/zeroize/reset, a 4-bit one for exhaustion.
module tb_aes_sync_provider;
  import aes_model_pack::*;

  logic         clk;
  logic         rst;
  aes_block_t   key_in, key_in4;
  logic [63:0]  nonce_in;
  logic [123:0] nonce_in4;
  logic         key_load, key_load4;
  logic         zeroize, zeroize4;
  logic [63:0]  sync_count;
  logic [3:0]   sync_count4;
  logic         exhausted, exhausted4;

  int n_checks = 0;
  int n_fail   = 0;

  dvr_key_if ks_if ();
  dvr_key_if ks_if4 ();

  aes_sync_provider u_dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .nonce_in     (nonce_in),
    .key_load     (key_load),
    .zeroize      (zeroize),
    .key_and_sync (ks_if),
    .sync_count   (sync_count),
    .exhausted    (exhausted)
  );

  aes_sync_provider #(.COUNTER_WIDTH(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in4),
    .nonce_in     (nonce_in4),
    .key_load     (key_load4),
    .zeroize      (zeroize4),
    .key_and_sync (ks_if4),
    .sync_count   (sync_count4),
    .exhausted    (exhausted4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  localparam aes_block_t  K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [63:0] N1 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam aes_block_t  K2 = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam logic [63:0] N2 = 64'h0123_4567_89AB_CDEF;
  localparam aes_block_t  K3 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [123:0] N3 = 124'h123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  initial begin
    rst = 1'b0; key_load = 1'b0; zeroize = 1'b0; key_in = '0; nonce_in = '0;
    key_load4 = 1'b0; zeroize4 = 1'b0; key_in4 = '0; nonce_in4 = '0;
    ks_if.rdy = 1'b0; ks_if4.rdy = 1'b0;
    tick(); tick();

    chk("rst_valid",  128'(ks_if.valid), 128'd0);
    chk("rst_key",    ks_if.key, 128'd0);
    chk("rst_sync",   ks_if.sync, 128'd0);
    chk("rst_count",  128'(sync_count), 128'd0);
    chk("rst_exh",    128'(exhausted), 128'd0);
    chk("rst_valid4", 128'(ks_if4.valid), 128'd0);
    rst = 1'b1;
    tick();
    chk("idle_valid", 128'(ks_if.valid), 128'd0);

    // Load, then hold with rdy low
    key_load = 1'b1; key_in = K1; nonce_in = N1;
    tick();
    key_load = 1'b0; key_in = '0; nonce_in = '0;
    chk("load_valid", 128'(ks_if.valid), 128'd1);
    chk("load_key",   ks_if.key, K1);
    chk("load_sync",  ks_if.sync, {N1, 64'd0});
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", 128'(ks_if.valid), 128'd1);
      chk("hold_sync",  ks_if.sync, {N1, 64'd0});
      chk("hold_key",   ks_if.key, K1);
    end

    // Five back-to-back transfers
    for (int i = 0; i < 5; i++) begin
      chk("xfer_valid", 128'(ks_if.valid), 128'd1);
      chk("xfer_sync",  ks_if.sync, {N1, 64'(i)});
      ks_if.rdy = 1'b1;
      tick();
    end
    ks_if.rdy = 1'b0;
    chk("after5_count", 128'(sync_count), 128'd5);
    chk("after5_valid", 128'(ks_if.valid), 128'd1);

    // Reach counter 7, then load on the same edge as a transfer
    ks_if.rdy = 1'b1;
    tick(); tick();
    chk("pre_load_count", 128'(sync_count), 128'd7);
    chk("pre_load_key",   ks_if.key, K1);
    chk("pre_load_sync",  ks_if.sync, {N1, 64'd7});
    chk("pre_load_valid", 128'(ks_if.valid), 128'd1);
    key_load = 1'b1; key_in = K2; nonce_in = N2;
    tick();
    key_load = 1'b0; ks_if.rdy = 1'b0;
    chk("reload_key",   ks_if.key, K2);
    chk("reload_sync",  ks_if.sync, {N2, 64'd0});
    chk("reload_count", 128'(sync_count), 128'd0);
    chk("reload_valid", 128'(ks_if.valid), 128'd1);

    // Zeroize beats a simultaneous load
    zeroize = 1'b1; key_load = 1'b1; key_in = K1; nonce_in = N1;
    tick();
    zeroize = 1'b0; key_load = 1'b0;
    chk("zero_valid", 128'(ks_if.valid), 128'd0);
    chk("zero_key",   ks_if.key, 128'd0);
    chk("zero_sync",  ks_if.sync, 128'd0);
    chk("zero_count", 128'(sync_count), 128'd0);
    chk("zero_exh",   128'(exhausted), 128'd0);
    ks_if.rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zero_idle_valid", 128'(ks_if.valid), 128'd0);
    end
    ks_if.rdy = 1'b0;

    // 4-bit counter: exhaustion after 16 transfers
    key_load4 = 1'b1; key_in4 = K3; nonce_in4 = N3;
    tick();
    key_load4 = 1'b0;
    ks_if4.rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("w4_valid", 128'(ks_if4.valid), 128'd1);
      chk("w4_sync",  ks_if4.sync, {N3, 4'(i)});
      tick();
    end
    chk("w4_exh_valid", 128'(ks_if4.valid), 128'd0);
    chk("w4_exh_flag",  128'(exhausted4), 128'd1);
    chk("w4_exh_count", 128'(sync_count4), 128'd15);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("w4_stuck_valid", 128'(ks_if4.valid), 128'd0);
      chk("w4_stuck_count", 128'(sync_count4), 128'd15);
    end
    ks_if4.rdy = 1'b0;
    key_load4 = 1'b1; key_in4 = K2;
    tick();
    key_load4 = 1'b0;
    chk("w4_reload_valid", 128'(ks_if4.valid), 128'd1);
    chk("w4_reload_exh",   128'(exhausted4), 128'd0);
    chk("w4_reload_count", 128'(sync_count4), 128'd0);
    chk("w4_reload_key",   ks_if4.key, K2);

    // Asynchronous reset while offering
    key_load = 1'b1; key_in = K2; nonce_in = N2;
    tick();
    key_load = 1'b0;
    chk("pre_rst_valid", 128'(ks_if.valid), 128'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 128'(ks_if.valid), 128'd0);
    chk("async_rst_key",   ks_if.key, 128'd0);
    chk("async_rst_sync",  ks_if.sync, 128'd0);
    tick();
    rst = 1'b1;
    ks_if.rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", 128'(ks_if.valid), 128'd0);
    end
    ks_if.rdy = 1'b0;
    key_load = 1'b1; key_in = K1; nonce_in = N1;
    tick();
    key_load = 1'b0;
    chk("post_rst_load_valid", 128'(ks_if.valid), 128'd1);
    chk("post_rst_load_sync",  ks_if.sync, {N1, 64'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
